// File: rtl/sr_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sr_cmd_pkg
// Purpose  : Shared types and constants for the SR command generator.
// Contents : deb_state_e         - per-channel debounce FSM state
//            SR_CMD_DEBOUNCE_DEF - default debounce length in cycles
//            SR_CMD_CONFLICT_MAX - saturation value of the conflict counter
// Revision : 1.0 - initial release
// ============================================================================
package sr_cmd_pkg;

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    RISE_CHK = 2'd1,
    HIGH     = 2'd2,
    FALL_CHK = 2'd3
  } deb_state_e;

  localparam int         SR_CMD_DEBOUNCE_DEF = 4;
  localparam logic [7:0] SR_CMD_CONFLICT_MAX = 8'd255;

endpackage : sr_cmd_pkg
`default_nettype wire

// File: rtl/sr_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sr_debounce
// Purpose  : One request channel: 2-flop synchroniser, debounce FSM with a
//            run-length counter, and rising-edge detection of the filtered
//            level.
// Ports    : clk    in  clock
//            rst_n  in  asynchronous active-low reset
//            din    in  raw asynchronous request line
//            level  out filtered level (1 in HIGH / FALL_CHK)
//            rise   out one-cycle pulse, valid in the cycle whose closing edge
//                       moves the FSM into HIGH
// Revision : 1.0 - initial release
// ============================================================================
module sr_debounce
  import sr_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SR_CMD_DEBOUNCE_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] c_target = CNT_W'(DEBOUNCE_CYCLES);

  logic             r_sync1;
  logic             r_sync2;
  deb_state_e       r_state;
  deb_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= LOW;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The rise is Mealy: it is asserted during the cycle that completes the
  // count so the output register in the top captures it on that same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rise      = 1'b0;
    w_cnt_inc   = r_cnt + CNT_W'(1);
    unique case (r_state)
      LOW: begin
        if (r_sync2) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_state_nxt = HIGH;
            w_cnt_nxt   = '0;
            w_rise      = 1'b1;
          end else begin
            w_state_nxt = RISE_CHK;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
      end
      RISE_CHK: begin
        if (r_sync2) begin
          if (w_cnt_inc == c_target) begin
            w_state_nxt = HIGH;
            w_cnt_nxt   = '0;
            w_rise      = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end else begin
          // Glitch: level fell back before acceptance, restart from scratch.
          w_state_nxt = LOW;
          w_cnt_nxt   = '0;
        end
      end
      HIGH: begin
        if (!r_sync2) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_state_nxt = LOW;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = FALL_CHK;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
      end
      FALL_CHK: begin
        if (!r_sync2) begin
          if (w_cnt_inc == c_target) begin
            w_state_nxt = LOW;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end else begin
          w_state_nxt = HIGH;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign level = (r_state == HIGH) || (r_state == FALL_CHK);
  assign rise  = w_rise;

endmodule : sr_debounce
`default_nettype wire

// File: rtl/sr_cmd_gen.sv
`default_nettype none
// ============================================================================
// Module   : sr_cmd_gen
// Purpose  : Turns two raw, bouncy set/clear request lines into clean
//            one-cycle s / r pulses for an SR flip-flop. Coincident rises are
//            dropped and flagged on conflict, so {s,r} is never 2'b11.
// Ports    : clk          in  clock
//            rst_n        in  asynchronous active-low reset
//            set_req      in  raw set request
//            clr_req      in  raw clear request
//            s            out one-cycle set pulse
//            r            out one-cycle reset pulse
//            conflict     out one-cycle pulse on coincident rises
//            conflict_cnt out saturating count of conflict pulses
// Macro    : SR_CMD_CONFLICT_CNT_EN - when defined, conflict_cnt counts and
//            saturates at 255; otherwise it is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module sr_cmd_gen
  import sr_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SR_CMD_DEBOUNCE_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_req,
  input  logic       clr_req,
  output logic       s,
  output logic       r,
  output logic       conflict,
  output logic [7:0] conflict_cnt
);

  logic w_set_level;
  logic w_set_rise;
  logic w_clr_level;
  logic w_clr_rise;
  logic w_both;

  sr_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_set_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (set_req),
    .level (w_set_level),
    .rise  (w_set_rise)
  );

  sr_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_clr_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (clr_req),
    .level (w_clr_level),
    .rise  (w_clr_rise)
  );

  assign w_both = w_set_rise & w_clr_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s        <= 1'b0;
      r        <= 1'b0;
      conflict <= 1'b0;
    end else begin
      s        <= w_set_rise & ~w_clr_rise;
      r        <= w_clr_rise & ~w_set_rise;
      conflict <= w_both;
    end
  end

`ifdef SR_CMD_CONFLICT_CNT_EN
  logic [7:0] r_conflict_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= 8'd0;
    end else if (w_both && (r_conflict_cnt != SR_CMD_CONFLICT_MAX)) begin
      r_conflict_cnt <= r_conflict_cnt + 8'd1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
`else
  assign conflict_cnt = 8'd0;
`endif

  // A rise must always leave its channel in the filtered-high level.
  a_set_rise_level : assert property (@(posedge clk) disable iff (!rst_n)
    w_set_rise |=> w_set_level);
  a_clr_rise_level : assert property (@(posedge clk) disable iff (!rst_n)
    w_clr_rise |=> w_clr_level);

endmodule : sr_cmd_gen
`default_nettype wire

// File: tb/tb_sr_cmd_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_cmd_gen
// Purpose  : Self-checking bench for sr_cmd_gen with a behavioural model
//            (2-cycle sync delay followed by a run-length acceptance filter).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_cmd_gen;

  localparam int D = 4;
`ifdef SR_CMD_CONFLICT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       set_req;
  logic       clr_req;
  logic       s;
  logic       r;
  logic       conflict;
  logic [7:0] conflict_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  sr_cmd_gen #(.DEBOUNCE_CYCLES(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .set_req      (set_req),
    .clr_req      (clr_req),
    .s            (s),
    .r            (r),
    .conflict     (conflict),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit m_sync1 [2];
  bit m_sync2 [2];
  bit m_lvl   [2];
  int m_run   [2];
  bit exp_s, exp_r, exp_c;
  int exp_cnt;

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      m_sync1[ch] = 0; m_sync2[ch] = 0; m_lvl[ch] = 0; m_run[ch] = 0;
    end
    exp_s = 0; exp_r = 0; exp_c = 0; exp_cnt = 0;
  endtask

  // One clock edge: the filter sees the twice-delayed raw value; a new level
  // is accepted after D consecutive differing samples.
  task automatic model_edge(input bit a, input bit b);
    bit rise [2];
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int ch = 0; ch < 2; ch++) begin
      rise[ch] = 0;
      if (m_sync2[ch] != m_lvl[ch]) begin
        m_run[ch]++;
        if (m_run[ch] == D) begin
          m_lvl[ch] = ~m_lvl[ch];
          m_run[ch] = 0;
          rise[ch]  = m_lvl[ch];
        end
      end else begin
        m_run[ch] = 0;
      end
    end
    exp_s = rise[0] & ~rise[1];
    exp_r = rise[1] & ~rise[0];
    exp_c = rise[0] & rise[1];
    if (exp_c && CNT_EN && exp_cnt < 255) exp_cnt++;
    m_sync2[0] = m_sync1[0]; m_sync1[0] = a;
    m_sync2[1] = m_sync1[1]; m_sync1[1] = b;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_s"}, 32'(s), 32'(exp_s));
    chk({tag, "_r"}, 32'(r), 32'(exp_r));
    chk({tag, "_conflict"}, 32'(conflict), 32'(exp_c));
    chk({tag, "_cnt"}, 32'(conflict_cnt), 32'(exp_cnt));
    chk({tag, "_sr_excl"}, 32'(s & r), 32'd0);
  endtask

  // Drive inputs at the falling edge, advance the model at the rising edge,
  // compare shortly after.
  task automatic cyc(input bit a, input bit b, input bit rn, input string tag);
    @(negedge clk);
    set_req = a; clr_req = b; rst_n = rn;
    @(posedge clk);
    model_edge(a, b);
    #1;
    chk_all(tag);
  endtask

  initial begin
    int n_s, n_r, n_c, e_s, e_r, e_c;
    bit ra, rb, prev_s, prev_r, prev_c;

    rst_n = 1'b0; set_req = 1'b0; clr_req = 1'b0;
    model_reset();
    #1;
    chk_all("reset_async");
    cyc(0, 0, 0, "reset");
    cyc(0, 0, 0, "reset");
    cyc(0, 0, 1, "idle");
    cyc(0, 0, 1, "idle");

    // 1: set step and hold 20 cycles -> one s pulse after edge 5
    n_s = 0; n_r = 0; n_c = 0; e_s = -1;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 1, "t1");
      if (s) begin n_s++; e_s = i; end
      if (r) n_r++;
      if (conflict) n_c++;
    end
    chk("t1_s_count", n_s, 1);
    chk("t1_s_edge", e_s, D + 1);
    chk("t1_r_count", n_r, 0);
    chk("t1_c_count", n_c, 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, "t1_rel");

    // 2: clr bounces, then holds
    n_r = 0;
    cyc(0, 1, 1, "t2_b"); if (r) n_r++;
    cyc(0, 0, 1, "t2_b"); if (r) n_r++;
    cyc(0, 1, 1, "t2_b"); if (r) n_r++;
    cyc(0, 0, 1, "t2_b"); if (r) n_r++;
    e_r = -1;
    for (int i = 0; i < 15; i++) begin
      cyc(0, 1, 1, "t2");
      if (r) begin n_r++; e_r = i; end
    end
    chk("t2_r_count", n_r, 1);
    chk("t2_r_edge", e_r, D + 1);
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, "t2_rel");

    // 3: simultaneous rise -> one conflict, no s/r
    n_s = 0; n_r = 0; n_c = 0; e_c = -1;
    for (int i = 0; i < 12; i++) begin
      cyc(1, 1, 1, "t3");
      if (s) n_s++;
      if (r) n_r++;
      if (conflict) begin n_c++; e_c = i; end
    end
    chk("t3_c_count", n_c, 1);
    chk("t3_c_edge", e_c, D + 1);
    chk("t3_s_count", n_s, 0);
    chk("t3_r_count", n_r, 0);
    chk("t3_cnt", 32'(conflict_cnt), CNT_EN ? 32'd1 : 32'd0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, "t3_rel");

    // 4: 300 more conflicts -> counter saturates (or stays 0)
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 7; i++) cyc(1, 1, 1, "t4");
      for (int i = 0; i < 7; i++) cyc(0, 0, 1, "t4");
    end
    chk("t4_cnt_sat", 32'(conflict_cnt), CNT_EN ? 32'd255 : 32'd0);
    for (int i = 0; i < 7; i++) cyc(1, 1, 1, "t4_hold");
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, "t4_hold");
    chk("t4_cnt_hold", 32'(conflict_cnt), CNT_EN ? 32'd255 : 32'd0);

    // 5: reset pulse during RISE_CHK with set held
    cyc(1, 0, 1, "t5_pre");
    cyc(1, 0, 1, "t5_pre");
    cyc(1, 0, 1, "t5_pre");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("t5_async");
    cyc(1, 0, 0, "t5_rst");
    n_s = 0; e_s = -1;
    for (int i = 0; i < 15; i++) begin
      cyc(1, 0, 1, "t5");
      if (s) begin n_s++; e_s = i; end
    end
    chk("t5_s_count", n_s, 1);
    chk("t5_s_edge", e_s + 1, D + 2);
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, "t5_rel");

    // 6: random bouncy stimulus
    ra = 0; rb = 0; prev_s = 0; prev_r = 0; prev_c = 0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(7) == 0) ra = ~ra;
      if ($urandom_range(7) == 0) rb = ~rb;
      cyc(ra, rb, 1, "rnd");
      chk("rnd_s_width", 32'(s & prev_s), 32'd0);
      chk("rnd_r_width", 32'(r & prev_r), 32'd0);
      chk("rnd_c_width", 32'(conflict & prev_c), 32'd0);
      prev_s = s; prev_r = r; prev_c = conflict;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_sr_cmd_gen
`default_nettype wire
